// File: rtl/display_timing_if.sv
// Raster timing bundle between the timing generator (master) and a pixel consumer (slave).
interface display_timing_if;
  logic        enable;
  logic [10:0] h_pos;
  logic [10:0] v_pos;
  logic        hsync;
  logic        vsync;
  logic        data_enable;
  logic        frame_start;
  logic        line_start;
  logic        fetch_valid;
  logic [10:0] fetch_x;
  logic [10:0] fetch_y;

  modport master (
    input  enable,
    output h_pos, v_pos, hsync, vsync, data_enable, frame_start, line_start,
    output fetch_valid, fetch_x, fetch_y
  );

  modport slave (
    output enable,
    input  h_pos, v_pos, hsync, vsync, data_enable, frame_start, line_start,
    input  fetch_valid, fetch_x, fetch_y
  );
endinterface

// File: rtl/display_timing_gen.sv
// Raster timing generator: h/v counters with registered sync, active-video and start pulses.
// Optional lookahead fetch position is built only with DISPLAY_TIMING_FETCH_LOOKAHEAD_EN defined.
module display_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int FETCH_LEAD = 2
) (
  input logic              clk,
  input logic              rst,
  display_timing_if.master tim
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEGIN = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEGIN = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON    = (HSYNC_POL != 0);
  localparam logic        VS_ON    = (VSYNC_POL != 0);

  if (H_TOTAL > 2048 || V_TOTAL > 2048 || FETCH_LEAD < 1 || FETCH_LEAD >= H_TOTAL) begin : g_bad_params
    $error("display_timing_gen: illegal timing parameters");
  end

  function automatic logic in_active(input logic [10:0] h, input logic [10:0] v);
    return ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
  endfunction

  logic [10:0] hc, vc;
  logic        hc_wrap, vc_wrap, hs_act, vs_act;
  logic [10:0] h_pos_q, v_pos_q;
  logic        de_q, fs_q, ls_q, hs_q, vs_q;

  assign hc_wrap = (hc == H_LAST);
  assign vc_wrap = (vc == V_LAST);
  assign hs_act  = ({1'b0, hc} >= HS_BEGIN) && ({1'b0, hc} < HS_END);
  assign vs_act  = ({1'b0, vc} >= VS_BEGIN) && ({1'b0, vc} < VS_END);

  // Outputs describe the position held before the edge, so they lag the counters by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc      <= '0;
      vc      <= '0;
      h_pos_q <= '0;
      v_pos_q <= '0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
    end else if (tim.enable) begin
      hc <= hc_wrap ? '0 : hc + 11'd1;
      if (hc_wrap) vc <= vc_wrap ? '0 : vc + 11'd1;
      h_pos_q <= hc;
      v_pos_q <= vc;
      de_q    <= in_active(hc, vc);
      ls_q    <= (hc == '0);
      fs_q    <= (hc == '0) && (vc == '0);
      hs_q    <= hs_act ? HS_ON : ~HS_ON;
      vs_q    <= vs_act ? VS_ON : ~VS_ON;
    end
  end

  assign tim.h_pos       = h_pos_q;
  assign tim.v_pos       = v_pos_q;
  assign tim.data_enable = de_q;
  assign tim.frame_start = fs_q;
  assign tim.line_start  = ls_q;
  assign tim.hsync       = hs_q;
  assign tim.vsync       = vs_q;

`ifdef DISPLAY_TIMING_FETCH_LOOKAHEAD_EN
  logic [10:0] fc, fr, fx_q, fy_q;
  logic        fv_q, fc_wrap, fr_wrap;

  assign fc_wrap = (fc == H_LAST);
  assign fr_wrap = (fr == V_LAST);

  // Starts FETCH_LEAD pixels into line 0; FETCH_LEAD < H_TOTAL keeps the start row at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc   <= 11'(FETCH_LEAD);
      fr   <= '0;
      fx_q <= '0;
      fy_q <= '0;
      fv_q <= 1'b0;
    end else if (tim.enable) begin
      fc <= fc_wrap ? '0 : fc + 11'd1;
      if (fc_wrap) fr <= fr_wrap ? '0 : fr + 11'd1;
      fx_q <= fc;
      fy_q <= fr;
      fv_q <= in_active(fc, fr);
    end
  end

  assign tim.fetch_x     = fx_q;
  assign tim.fetch_y     = fy_q;
  assign tim.fetch_valid = fv_q;
`else
  assign tim.fetch_x     = '0;
  assign tim.fetch_y     = '0;
  assign tim.fetch_valid = 1'b0;
`endif
endmodule

// File: tb/tb_display_timing_gen.sv
// Randomized-enable bench for display_timing_gen on a reduced raster, checked against
// an arithmetic model: presented position = (enabled edges since reset - 1) mod frame size.
module tb_display_timing_gen;
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 4;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int LEAD = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  display_timing_if tim();

  display_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(0), .FETCH_LEAD(LEAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tim(tim)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int en_edges = 0;
  int last_fs = -1;
  int last_ls = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int cur_h();
    return (n == 0) ? -1 : ((n - 1) % FRAME) % HT;
  endfunction

  function automatic int cur_v();
    return (n == 0) ? -1 : ((n - 1) % FRAME) / HT;
  endfunction

  task automatic check_outputs();
    int p, h, v, q, fx, fy;
    int de, fs, ls, hs, vs, fv;
    h = 0; v = 0; de = 0; fs = 0; ls = 0; hs = 1; vs = 1;
    fx = 0; fy = 0; fv = 0;
    if (n != 0) begin
      p  = (n - 1) % FRAME;
      h  = p % HT;
      v  = p / HT;
      de = (h < HA && v < VA) ? 1 : 0;
      ls = (h == 0) ? 1 : 0;
      fs = (p == 0) ? 1 : 0;
      hs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
      vs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
`ifdef DISPLAY_TIMING_FETCH_LOOKAHEAD_EN
      q  = (p + LEAD) % FRAME;
      fx = q % HT;
      fy = q / HT;
      fv = (fx < HA && fy < VA) ? 1 : 0;
`else
      q  = 0;
`endif
    end
    chk("h_pos",       32'(tim.h_pos),       h);
    chk("v_pos",       32'(tim.v_pos),       v);
    chk("data_enable", 32'(tim.data_enable), de);
    chk("frame_start", 32'(tim.frame_start), fs);
    chk("line_start",  32'(tim.line_start),  ls);
    chk("hsync",       32'(tim.hsync),       hs);
    chk("vsync",       32'(tim.vsync),       vs);
    chk("fetch_x",     32'(tim.fetch_x),     fx);
    chk("fetch_y",     32'(tim.fetch_y),     fy);
    chk("fetch_valid", 32'(tim.fetch_valid), fv);
  endtask

  task automatic step(input logic en);
    tim.enable = en;
    @(posedge clk);
    if (!rst && en) begin
      n++;
      en_edges++;
    end
    @(negedge clk);
    check_outputs();
    if (!rst && en) begin
      if (tim.frame_start === 1'b1) begin
        if (last_fs >= 0) chk("fs_period", en_edges - last_fs, FRAME);
        last_fs = en_edges;
      end
      if (tim.line_start === 1'b1) begin
        if (last_ls >= 0) chk("ls_period", en_edges - last_ls, HT);
        last_ls = en_edges;
      end
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    int guard = 0;
    while (!(cur_h() == h && cur_v() == v) && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    chk(tag, (guard < 2 * FRAME) ? 1 : 0, 1);
  endtask

  initial begin
    tim.enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 2 * FRAME + 5; i++) step(1'b1);

    // Freeze on the last active pixel of the frame, then resume into front porch.
    run_to(HA - 1, VA - 1, "reach_last_active");
    repeat (7) step(1'b0);
    step(1'b1);
    chk("resume_h", 32'(tim.h_pos), HA);
    chk("resume_de", 32'(tim.data_enable), 0);

    for (int i = 0; i < 3 * FRAME; i++) step($urandom_range(0, 9) < 8);

    // Mid-frame asynchronous reset, asserted between clock edges.
    run_to(HT / 2, VT / 2, "reach_mid_frame");
    #2 rst = 1'b1;
    #1;
    n = 0;
    last_fs = -1;
    last_ls = -1;
    check_outputs();
    repeat (3) step($urandom_range(0, 1) == 1);
    rst = 1'b0;
    step(1'b1);
    chk("post_reset_fs", 32'(tim.frame_start), 1);

    for (int i = 0; i < FRAME + 40; i++) step($urandom_range(0, 9) < 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, hsync width clocks
- H_BP, 48, horizontal back porch clocks
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync width lines
- V_BP, 33, vertical back porch lines
- HSYNC_POL, 0, hsync asserted level
- VSYNC_POL, 0, vsync asserted level
- FETCH_LEAD, 2, lookahead distance in clocks
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk, input, 1, pixel clock
- rst, input, 1, reset, asynchronous, active-high
- enable, input, 1, advance timing when high
- h_pos, output, 11, current horizontal count
- v_pos, output, 11, current vertical count
- hsync, output, 1, horizontal sync at HSYNC_POL when asserted
- vsync, output, 1, vertical sync at VSYNC_POL when asserted
- data_enable, output, 1, active video
- frame_start, output, 1, one-clock pulse at position (0,0)
- line_start, output, 1, one-clock pulse at h_pos==0
- fetch_valid, output, 1, lookahead position is active (lookahead build only)
- fetch_x, output, 11, lookahead h count (lookahead build only)
- fetch_y, output, 11, lookahead v count (lookahead build only)
REQ-003 SHALL require H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP ≤ 2048, V_TOTAL defined likewise ≤ 2048, and 1 ≤ FETCH_LEAD < H_TOTAL.

Function
REQ-004 SHALL keep internal position counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1); on each clk edge with enable=1, hc increments and wraps to 0 after H_TOTAL-1; vc increments only on hc wrap and wraps to 0 after V_TOTAL-1.
REQ-005 SHALL register all outputs from the current (hc,vc) at each enabled edge, so outputs describe the position held before that edge (one-clock latency).
REQ-006 SHALL drive data_enable = (h<H_ACTIVE) && (v<H_ACTIVE-independent V_ACTIVE bound, i.e. v<V_ACTIVE).
REQ-007 SHALL assert hsync when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
REQ-008 SHALL assert vsync for whole lines with V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, changing coincident with h=0.
REQ-009 SHALL pulse line_start when h==0 and frame_start when h==0 && v==0, each for exactly one enabled clock.
REQ-010 SHALL drive h_pos/v_pos as raw counts, including blanking, zero-extended to 11 bits.
REQ-011 SHALL, with enable=0, freeze all counters and hold all outputs, with pulses held as well; resuming continues from the frozen position with no skipped or repeated position.
REQ-012 SHALL produce exactly H_TOTAL*V_TOTAL enabled clocks per frame, with no extra cycle at line or frame wrap.

Reset
REQ-013 SHALL, while rst=1 and regardless of clk, drive hc=vc=0, h_pos=v_pos=0, data_enable=0, frame_start=0, line_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, fetch_valid=0, fetch_x=fetch_y=0.
REQ-014 SHALL present position (0,0) at the first enabled edge after rst deasserts (data_enable=1, frame_start=1, line_start=1); reset mid-frame abandons the frame with no partial pulse.

Configuration
REQ-015 SHALL compile the lookahead feature only when DISPLAY_TIMING_FETCH_LOOKAHEAD_EN is defined: a second counter pair runs exactly FETCH_LEAD positions ahead of (hc,vc), wrapping across line and frame ends, and registered fetch_x/fetch_y/fetch_valid follow the same rules as REQ-005, REQ-006 and REQ-011.
REQ-016 SHALL, without DISPLAY_TIMING_FETCH_LOOKAHEAD_EN, tie fetch_valid, fetch_x and fetch_y to 0 and instantiate no lookahead counters.

Verification
REQ-017 Release reset, enable=1, default params -> first edge h_pos=0, v_pos=0, data_enable=1, frame_start=1; the next frame_start occurs exactly 420000 clocks later.
REQ-018 Line 0 -> data_enable high for h 0..639; hsync low for h 656..751 and high otherwise; line_start every 800 clocks.
REQ-019 Full frame -> vsync low exactly for v=490..491 (1600 clocks), edges at h=0; data_enable never high for v ≥ 480.
REQ-020 Drop enable for 7 clocks at h=639, v=479 -> outputs held for all 7 clocks; after re-enable the next position is h=640 with data_enable=0.
REQ-021 With the lookahead macro defined and FETCH_LEAD=2, at h=798, v=524 -> fetch_x=0, fetch_y=0, fetch_valid=1; at h=638 -> fetch_x=640, fetch_valid=0.
REQ-022 Assert rst at h=300, v=200, hold for 3 clocks -> all outputs match REQ-013 immediately (asynchronously); after release the first edge gives h_pos=0, v_pos=0, frame_start=1.
